// File: rtl/sum_window_stats_if.sv
// sum_window_stats_if: sample input and result output handshakes of the window statistics block.
interface sum_window_stats_if #(
  parameter int IN_W = 9,
  parameter int LOG2_WIN = 3
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic                out_valid;
  logic                out_ready;
  logic [IN_W-1:0]     out_mean;
  logic [IN_W-1:0]     out_min;
  logic [IN_W-1:0]     out_max;
  logic [LOG2_WIN-1:0] win_cnt;
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_mean, out_min, out_max, win_cnt
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_mean, out_min, out_max, win_cnt
  );
endinterface

// File: rtl/sum_window_stats.sv
// sum_window_stats: mean/min/max over windows of 2**LOG2_WIN sum samples, single-entry result register.
module sum_window_stats #(
  parameter int IN_W = 9,
  parameter int LOG2_WIN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  sum_window_stats_if.slave bus
);
  localparam int AW = IN_W + LOG2_WIN;
  localparam logic [LOG2_WIN-1:0] LAST = LOG2_WIN'((1 << LOG2_WIN) - 1);
  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [IN_W-1:0] min_q, min_d, max_q, max_d, smin, smax;
  logic [IN_W-1:0] mean_q, mean_d, omin_q, omin_d, omax_q, omax_d;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic ov_q, ov_d, fire, close;
  // Stall only when the closing sample would overwrite a result nobody is taking.
  assign bus.in_ready = !(cnt_q == LAST && ov_q && !bus.out_ready);
  assign fire = bus.in_valid && bus.in_ready && !clr;
  assign close = fire && cnt_q == LAST;
  assign acc_sum = acc_q + AW'(bus.in_data);
  assign smin = bus.in_data < min_q ? bus.in_data : min_q;
  assign smax = bus.in_data > max_q ? bus.in_data : max_q;
  always_comb begin
    acc_d = clr || close ? '0 : fire ? acc_sum : acc_q;
    min_d = clr || close ? '1 : fire ? smin : min_q;
    max_d = clr || close ? '0 : fire ? smax : max_q;
    cnt_d = clr ? '0 : fire ? cnt_q + 1'b1 : cnt_q;
    ov_d = clr ? 1'b0 : close ? 1'b1 : ov_q && !bus.out_ready;
    mean_d = close ? acc_sum[AW-1:LOG2_WIN] : mean_q;
    omin_d = close ? smin : omin_q;
    omax_d = close ? smax : omax_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      min_q <= '1;
      max_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
      mean_q <= '0;
      omin_q <= '0;
      omax_q <= '0;
    end else begin
      acc_q <= acc_d;
      min_q <= min_d;
      max_q <= max_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
      mean_q <= mean_d;
      omin_q <= omin_d;
      omax_q <= omax_d;
    end
  end
  assign bus.out_valid = ov_q;
  assign bus.out_mean = mean_q;
  assign bus.out_min = omin_q;
  assign bus.out_max = omax_q;
  assign bus.win_cnt = cnt_q;
endmodule

// File: tb/tb_sum_window_stats.sv
// tb_sum_window_stats: directed window table, stall/clr/reset sequences and a throttled scoreboard run.
module tb_sum_window_stats;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  int ncmp = 0;
  int nfail = 0;
  sum_window_stats_if #(.IN_W(9), .LOG2_WIN(3)) bus ();
  sum_window_stats #(.IN_W(9), .LOG2_WIN(3)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [0:7][8:0] s;
    logic [8:0] mean;
    logic [8:0] mn;
    logic [8:0] mx;
  } vec_t;
  vec_t tbl[7];
  logic [8:0] exp_q[$];
  int got = 0;

  task automatic chk(input string nm, input int a, input int e);
    ncmp++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic chk_res(input string nm, input int m, input int lo, input int hi);
    chk({nm, "_mean"}, int'(bus.out_mean), m);
    chk({nm, "_min"}, int'(bus.out_min), lo);
    chk({nm, "_max"}, int'(bus.out_max), hi);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic push(input logic [8:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    #1;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) chk("push_accept", int'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [8:0] v;
    int sum, mn, mx;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    tbl[0] = '{{9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd6, 9'd7, 9'd8}, 9'd4, 9'd1, 9'd8};
    tbl[1] = '{{9'd511, 9'd511, 9'd511, 9'd511, 9'd511, 9'd511, 9'd511, 9'd511}, 9'd511, 9'd511, 9'd511};
    tbl[2] = '{{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0}, 9'd0, 9'd0, 9'd0};
    tbl[3] = '{{9'd10, 9'd20, 9'd30, 9'd40, 9'd50, 9'd60, 9'd70, 9'd80}, 9'd45, 9'd10, 9'd80};
    tbl[4] = '{{9'd3, 9'd3, 9'd3, 9'd3, 9'd3, 9'd3, 9'd3, 9'd3}, 9'd3, 9'd3, 9'd3};
    tbl[5] = '{{9'd0, 9'd511, 9'd0, 9'd511, 9'd0, 9'd511, 9'd0, 9'd511}, 9'd255, 9'd0, 9'd511};
    tbl[6] = '{{9'd100, 9'd7, 9'd250, 9'd9, 9'd300, 9'd42, 9'd1, 9'd77}, 9'd98, 9'd1, 9'd300};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_win_cnt", int'(bus.win_cnt), 0);
    chk_res("rst", 0, 0, 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < 8; i++) begin
        push(tbl[k].s[i]);
        if (i < 7) chk($sformatf("tbl%0d_cnt%0d", k, i), int'(bus.win_cnt), i + 1);
        if (i < 7 && k == 0) chk($sformatf("tbl0_noval%0d", i), int'(bus.out_valid), 0);
      end
      chk($sformatf("tbl%0d_valid", k), int'(bus.out_valid), 1);
      chk($sformatf("tbl%0d_wrap", k), int'(bus.win_cnt), 0);
      chk_res($sformatf("tbl%0d", k), int'(tbl[k].mean), int'(tbl[k].mn), int'(tbl[k].mx));
    end
    @(negedge clk);
    chk("pulse_end", int'(bus.out_valid), 0);

    // Back-to-back stall: second closing sample waits for the first result to leave.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(9'(i));
    for (int i = 20; i < 27; i++) push(9'(i));
    chk("stall_cnt", int'(bus.win_cnt), 7);
    chk("stall_valid", int'(bus.out_valid), 1);
    bus.in_valid = 1'b1;
    bus.in_data = 9'd27;
    repeat (3) begin
      #1;
      chk("stall_ready", int'(bus.in_ready), 0);
      chk_res("stall_hold", 4, 1, 8);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("unstall_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_valid", int'(bus.out_valid), 1);
    chk("b2b_cnt", int'(bus.win_cnt), 0);
    chk_res("b2b", 23, 20, 27);
    @(negedge clk);
    chk("b2b_drain", int'(bus.out_valid), 0);

    // clr drops the pending result and the partial window; result values hold.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 13; i++) push(9'd5);
    chk("preclr_valid", int'(bus.out_valid), 1);
    chk("preclr_cnt", int'(bus.win_cnt), 5);
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 9'd99;
    @(negedge clk);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_cnt", int'(bus.win_cnt), 0);
    chk("clr_valid", int'(bus.out_valid), 0);
    chk_res("clr_hold", 5, 5, 5);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(9'(10 * i));
    chk("postclr_valid", int'(bus.out_valid), 1);
    chk_res("postclr", 45, 10, 80);
    @(negedge clk);

    // Asynchronous reset mid-window with a pending result.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) push(9'd9);
    chk("prerst_valid", int'(bus.out_valid), 1);
    chk("prerst_cnt", int'(bus.win_cnt), 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(bus.out_valid), 0);
    chk("arst_cnt", int'(bus.win_cnt), 0);
    chk_res("arst", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(9'(i));
    chk("postrst_valid", int'(bus.out_valid), 1);
    chk_res("postrst", 4, 1, 8);
    @(negedge clk);

    // Randomly throttled traffic against a scoreboard.
    fork
      begin
        for (int w = 0; w < 1000; w++) begin
          sum = 0;
          mn = 511;
          mx = 0;
          for (int i = 0; i < 8; i++) begin
            v = 9'($urandom_range(0, 511));
            sum += int'(v);
            if (int'(v) < mn) mn = int'(v);
            if (int'(v) > mx) mx = int'(v);
            repeat ($urandom_range(0, 1)) @(negedge clk);
            if (i == 7) begin
              exp_q.push_back(9'(sum / 8));
              exp_q.push_back(9'(mn));
              exp_q.push_back(9'(mx));
            end
            push(v);
          end
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < 1000 && cyc < 60000) begin
          @(negedge clk);
          bus.out_ready = $urandom_range(0, 1) == 1;
          cyc++;
          if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() < 3) chk("sb_extra_result", exp_q.size(), 3);
            else chk_res($sformatf("sb%0d", got), int'(exp_q.pop_front()), int'(exp_q.pop_front()), int'(exp_q.pop_front()));
            got++;
          end
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_results", got, 1000);
    chk("sb_leftover", exp_q.size(), 0);
    chk("sb_final_cnt", int'(bus.win_cnt), 0);
    chk("sb_final_valid", int'(bus.out_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
